// File: rtl/shadow_centroid.sv
// shadow_centroid: accumulates the shadow-mask pixel coordinates over a frame.
// At end of frame it divides the coordinate sums by the pixel count with a
// restoring shift-subtract divider, so x_out/y_out give the mask centroid.
// The x and y divisions run in parallel, one quotient bit per cycle.
// Optional feature: defining SHADOW_CENTROID_MIN_COUNT_EN makes the block ignore
// any frame with fewer than MIN_PIXELS mask pixels.
module shadow_centroid #(
  parameter int MIN_PIXELS = 64,
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        valid_in,
  input  logic        frame_done_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        valid_out,
  output logic        busy_out
);

  // SW is the sum width. RW holds a partial remainder, which is always below
  // twice the divisor, so it needs one bit more than the count.
  localparam int SW  = DIV_CYCLES;
  localparam int CW  = 21;
  localparam int RW  = CW + 1;
  localparam int ITW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {ACCUM, DIVIDE, OUTPUT} state_t;

  state_t state_q, state_d;

  // Lane 0 is x, lane 1 is y.
  logic [1:0][SW-1:0] coord;
  logic [1:0][SW-1:0] sum_q, sum_d, sum_inc;
  logic [CW-1:0]      count_q, count_d, count_inc;

  logic [1:0][SW-1:0] dvd_q, dvd_d, dvd_next;
  logic [1:0][RW-1:0] rem_q, rem_d, rem_next, rem_shift;
  logic [1:0]         ge;
  logic [CW-1:0]      div_q, div_d;
  logic [ITW-1:0]     iter_q, iter_d;

  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;

  logic snap_en;
  logic last_iter;
  logic usable;

  assign coord[0]  = SW'(hcount_in);
  assign coord[1]  = SW'(vcount_in);
  assign count_inc = count_q + CW'(valid_in);
  assign last_iter = (iter_q == ITW'(DIV_CYCLES - 1));

  // A pixel that arrives together with frame_done still belongs to the frame
  // being closed, so the snapshot is taken from the incremented sums.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign sum_inc[gi]   = sum_q[gi] + (valid_in ? coord[gi] : '0);
      assign rem_shift[gi] = {rem_q[gi][RW-2:0], dvd_q[gi][SW-1]};
      assign ge[gi]        = (rem_shift[gi] >= RW'(div_q));
      assign rem_next[gi]  = ge[gi] ? (rem_shift[gi] - RW'(div_q)) : rem_shift[gi];
      assign dvd_next[gi]  = {dvd_q[gi][SW-2:0], ge[gi]};
    end
  endgenerate

  // Decide whether the snapshot count is worth dividing.
`ifdef SHADOW_CENTROID_MIN_COUNT_EN
  assign usable = (count_inc >= CW'(MIN_PIXELS));
`else
  assign usable = (count_inc != '0);
  localparam int unused_min_pixels = MIN_PIXELS;
`endif

  // Quotient bits above the output widths are always zero for in-range
  // coordinates; the remainder MSB is never shifted out.
  logic unused_bits;
  assign unused_bits = ^{dvd_next[0][SW-1:11], dvd_next[1][SW-1:10],
                         rem_q[0][RW-1], rem_q[1][RW-1]};

  // Next-state logic: a snapshot is taken only in ACCUM; a frame end seen in
  // DIVIDE or OUTPUT is dropped (accumulators still clear).
  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    case (state_q)
      ACCUM: begin
        if (frame_done_in) begin
          snap_en = 1'b1;
          if (usable) state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        if (last_iter) state_d = OUTPUT;
      end
      OUTPUT: begin
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  // Accumulator, divider and output register next values.
  always_comb begin
    sum_d   = sum_inc;
    count_d = count_inc;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    if (frame_done_in) begin
      sum_d   = '0;
      count_d = '0;
    end
    if (snap_en) begin
      dvd_d  = sum_inc;
      rem_d  = '0;
      div_d  = count_inc;
      iter_d = '0;
    end else if (state_q == DIVIDE) begin
      dvd_d  = dvd_next;
      rem_d  = rem_next;
      iter_d = iter_q + ITW'(1);
      if (last_iter) begin
        x_d = dvd_next[0][10:0];
        y_d = dvd_next[1][9:0];
      end
    end
  end

  // State and datapath registers; reset discards any pending division.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      count_q <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign valid_out = (state_q == OUTPUT);
  assign busy_out  = (state_q == DIVIDE);

endmodule
